sar_adc_seq: RTL and testbench
==============================

SAR_ADC_SEQ -- requirements
Module: sar_adc_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the conversion resolution in bits (legal range 2..16).
REQ-002 SHALL have parameter NUM_CH, default 4, the number of analog channels (legal range 1..16); CH_W = max(1, clog2(NUM_CH)).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1, the DAC and mux settle cycles before a comparator sample (must be >= 1).
REQ-004 SHALL have parameter AVG_LOG2, default 2; averaging uses 2^AVG_LOG2 samples and is used only under SAR_AVG_EN.
REQ-005 SHALL use one clock and an asynchronous active-high reset, listed first in the port list:
  - clk  in  1  rising-edge clock
  - rst  in  1  asynchronous active-high reset
  - start  in  1  scan request pulse
  - ch_mask  in  NUM_CH  channels enabled for the scan
  - compares  in  1  comparator output; 1 = analog input >= DAC voltage
  - dac_code  out  WIDTH  trial code driven to the DAC
  - ch_sel  out  CH_W  analog mux select
  - busy  out  1  scan in progress
  - result_valid  out  1  one-cycle pulse marking a new result
  - result  out  WIDTH  converted code
  - result_ch  out  CH_W  channel of result

Function
REQ-006 SHALL implement the FSM states IDLE, MUX_SETTLE, BIT and NEXT_CH (the next channel is selected combinationally inside BIT).
REQ-007 SHALL accept start only in IDLE with ch_mask != 0: ch_mask is latched, busy rises at that edge, ch_sel becomes the lowest enabled channel, and the state goes to MUX_SETTLE.
REQ-008 SHALL ignore start while busy, and SHALL ignore start with ch_mask == 0 (no busy, no result).
REQ-009 SHALL stay in MUX_SETTLE for SETTLE_CYCLES cycles, holding dac_code at 0.
REQ-010 SHALL process bits in BIT from bit WIDTH-1 down to bit 0:
  - dac_code = accumulated code with the trial bit set.
  - The trial bit is held for SETTLE_CYCLES+1 cycles.
  - compares is sampled on the final cycle: 1 keeps the bit, 0 clears it.
REQ-011 SHALL, at the bit-0 decision edge, register result and result_ch and pulse result_valid high for exactly one cycle.
REQ-012 SHALL give latency from the start-accept edge to result_valid high of SETTLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) cycles per channel (17 for the defaults).
REQ-013 SHALL, at that same edge, advance ch_sel to the next higher enabled channel in the latched mask and enter MUX_SETTLE.
REQ-014 SHALL, when no further enabled channel exists, go to IDLE with busy falling at that same edge.
REQ-015 SHALL hold result and result_ch until the next result and SHALL never modify them mid-conversion.
REQ-016 SHALL be insensitive to ch_mask changes during a scan.

Reset
REQ-017 SHALL on rst, at any time including mid-conversion, immediately force:
  - state IDLE
  - dac_code 0, ch_sel 0
  - busy 0, result_valid 0
  - result 0, result_ch 0
  - latched mask, accumulators and counters 0

Configuration
REQ-018 SHALL, with SAR_AVG_EN defined:
  - convert each channel 2^AVG_LOG2 consecutive times, with a MUX_SETTLE only before the first sample;
  - sum the samples in WIDTH+AVG_LOG2 bits;
  - output result = sum >> AVG_LOG2 (truncating);
  - pulse result_valid only after the last sample.
REQ-019 SHALL, without SAR_AVG_EN, perform a single conversion per channel with no averaging logic or AVG_LOG2-dependent hardware.

Structure
REQ-020 SHALL place the FSM state enum, the CH_W computation function and reset constants in shared package sar_adc_pkg.
REQ-021 SHALL implement next-enabled-channel selection in sub-module sar_ch_pick, a combinational priority search above the current channel.

Verification
REQ-022 SHALL verify, with defaults, a comparator model and vin=0x80 on ch0, mask 4'b0001, start: result 0x80, result_ch 0, result_valid exactly 17 cycles after the accept edge, and busy low in the same cycle.
REQ-023 SHALL verify with vin=0x00 that result is 0x00, and with vin=0xFF that result is 0xFF and the dac_code trial sequence is 0x80, 0xC0, ..., 0xFF.
REQ-024 SHALL verify, with mask 4'b1010 and vin ch1=0x35, ch3=0xCA, that there are exactly two result_valid pulses (ch1=0x35, then ch3=0xCA) and ch0 and ch2 are never selected.
REQ-025 SHALL verify that a start pulse mid-scan and start with mask 0 in IDLE both have no effect on busy, results or latency.
REQ-026 SHALL verify that rst asserted during bit 4 of a conversion clears all outputs immediately and that a subsequent start converts correctly from scratch.
REQ-027 SHALL verify, with SAR_AVG_EN and AVG_LOG2=2, samples of 0x10, 0x11, 0x11, 0x12 (comparator dithered): a single result 0x11 after 4 conversions.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// Shared definitions for the SAR ADC scan sequencer: FSM state encoding,
// mux-select width helper and reset constants.
// Imported by sar_adc_seq and its sub-module.
package sar_adc_pkg;

  // NEXT_CH is part of the encoding, but the channel hop is folded into the
  // bit-0 decision cycle of BIT, so the FSM never dwells in it.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MUX_SETTLE = 2'd1,
    BIT        = 2'd2,
    NEXT_CH    = 2'd3
  } sar_state_t;

  // Mux select width: at least one bit, even for a single channel.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  localparam sar_state_t RST_STATE = IDLE;
  localparam logic       RST_FLAG  = 1'b0;

endpackage

// File: rtl/sar_ch_pick.sv
// Next-enabled-channel search: finds the lowest set bit of mask strictly
// above cur (or at/above cur when incl is set). Purely combinational.
// Ports: mask/cur/incl in; found (any candidate) and next_ch out.
module sar_ch_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  input  logic              incl,
  output logic              found,
  output logic [CH_W-1:0]   next_ch
);

  // Scan from the top down so the last hit, i.e. the lowest qualifying
  // channel, wins.
  always_comb begin
    found   = 1'b0;
    next_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
        found   = 1'b1;
        next_ch = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/sar_adc_seq.sv
// Multi-channel SAR ADC scan sequencer: settles the mux, runs a binary search
// on the DAC per enabled channel, and reports one result per channel.
// Optional build macro SAR_AVG_EN: average 2^AVG_LOG2 conversions per channel.
// Ports: clk/rst; start + ch_mask request a scan; compares from comparator;
// dac_code/ch_sel drive the analog side; busy, result_valid/result/result_ch.
module sar_adc_seq
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NUM_CH        = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int AVG_LOG2      = 2,
  localparam int CH_W         = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              compares,
  output logic [WIDTH-1:0]  dac_code,
  output logic [CH_W-1:0]   ch_sel,
  output logic              busy,
  output logic              result_valid,
  output logic [WIDTH-1:0]  result,
  output logic [CH_W-1:0]   result_ch
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1) + 1;
  localparam int BI_W  = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 16 || NUM_CH < 1 || NUM_CH > 16 ||
      SETTLE_CYCLES < 1 || AVG_LOG2 < 0) begin : g_bad_param
    $error("sar_adc_seq: parameter out of range");
  end

  sar_state_t        state_q, state_nxt;
  logic [NUM_CH-1:0] mask_q, mask_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [BI_W-1:0]   bit_idx_q, bit_idx_nxt;
  logic [WIDTH-1:0]  acc_q, acc_nxt;
  logic [CH_W-1:0]   ch_sel_nxt;
  logic              valid_nxt;
  logic [WIDTH-1:0]  result_nxt;
  logic [CH_W-1:0]   result_ch_nxt;
  logic [WIDTH-1:0]  trial, decided, fin_code;
  logic              last_samp;

`ifdef SAR_AVG_EN
  localparam int SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SMP_W-1:0] SAMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
  logic [WIDTH+AVG_LOG2-1:0] sum_q, sum_nxt, sum_total;
  logic [SMP_W-1:0]          samp_q, samp_nxt;
`endif

  // In IDLE the search looks at the incoming mask from channel 0 inclusive;
  // during a scan it looks strictly above the current channel in the latched mask.
  logic [NUM_CH-1:0] pick_mask;
  logic [CH_W-1:0]   pick_cur;
  logic              pick_found;
  logic [CH_W-1:0]   pick_next;

  assign pick_mask = (state_q == IDLE) ? ch_mask : mask_q;
  assign pick_cur  = (state_q == IDLE) ? '0 : ch_sel;

  sar_ch_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .mask    (pick_mask),
    .cur     (pick_cur),
    .incl    (state_q == IDLE),
    .found   (pick_found),
    .next_ch (pick_next)
  );

  assign trial   = acc_q | (WIDTH'(1) << bit_idx_q);
  assign decided = compares ? trial : acc_q;
  assign busy    = (state_q != IDLE);

`ifdef SAR_AVG_EN
  assign sum_total = sum_q + (WIDTH + AVG_LOG2)'(decided);
  assign fin_code  = WIDTH'(sum_total >> AVG_LOG2);
  assign last_samp = (samp_q == SAMP_LAST);
`else
  assign fin_code  = decided;
  assign last_samp = 1'b1;
`endif

  always_comb begin
    state_nxt     = state_q;
    mask_nxt      = mask_q;
    cnt_nxt       = cnt_q;
    bit_idx_nxt   = bit_idx_q;
    acc_nxt       = acc_q;
    ch_sel_nxt    = ch_sel;
    valid_nxt     = 1'b0;
    result_nxt    = result;
    result_ch_nxt = result_ch;
    dac_code      = '0;
`ifdef SAR_AVG_EN
    sum_nxt       = sum_q;
    samp_nxt      = samp_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && pick_found) begin
          mask_nxt   = ch_mask;
          ch_sel_nxt = pick_next;
          cnt_nxt    = '0;
          acc_nxt    = '0;
          state_nxt  = MUX_SETTLE;
`ifdef SAR_AVG_EN
          sum_nxt    = '0;
          samp_nxt   = '0;
`endif
        end
      end
      MUX_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_nxt     = '0;
          acc_nxt     = '0;
          bit_idx_nxt = BI_W'(WIDTH - 1);
          state_nxt   = BIT;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      BIT: begin
        dac_code = trial;
        if (cnt_q != CNT_W'(SETTLE_CYCLES)) begin
          cnt_nxt = cnt_q + 1'b1;
        end else begin
          cnt_nxt = '0;
          if (bit_idx_q != '0) begin
            acc_nxt     = decided;
            bit_idx_nxt = bit_idx_q - 1'b1;
          end else if (!last_samp) begin
            // Back-to-back sample on the same channel: mux is already settled.
            acc_nxt     = '0;
            bit_idx_nxt = BI_W'(WIDTH - 1);
`ifdef SAR_AVG_EN
            sum_nxt     = sum_total;
            samp_nxt    = samp_q + 1'b1;
`endif
          end else begin
            valid_nxt     = 1'b1;
            result_nxt    = fin_code;
            result_ch_nxt = ch_sel;
            acc_nxt       = '0;
`ifdef SAR_AVG_EN
            sum_nxt       = '0;
            samp_nxt      = '0;
`endif
            if (pick_found) begin
              ch_sel_nxt = pick_next;
              state_nxt  = MUX_SETTLE;
            end else begin
              mask_nxt  = '0;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RST_STATE;
      mask_q       <= '0;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      acc_q        <= '0;
      ch_sel       <= '0;
      result_valid <= RST_FLAG;
      result       <= '0;
      result_ch    <= '0;
`ifdef SAR_AVG_EN
      sum_q        <= '0;
      samp_q       <= '0;
`endif
    end else begin
      state_q      <= state_nxt;
      mask_q       <= mask_nxt;
      cnt_q        <= cnt_nxt;
      bit_idx_q    <= bit_idx_nxt;
      acc_q        <= acc_nxt;
      ch_sel       <= ch_sel_nxt;
      result_valid <= valid_nxt;
      result       <= result_nxt;
      result_ch    <= result_ch_nxt;
`ifdef SAR_AVG_EN
      sum_q        <= sum_nxt;
      samp_q       <= samp_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sar_adc_seq.sv
// Directed bench for sar_adc_seq with default parameters and an ideal
// comparator model driven from per-channel input codes.
module tb_sar_adc_seq;

`ifdef SAR_AVG_EN
  localparam int NSAMP = 4;
`else
  localparam int NSAMP = 1;
`endif
  localparam int LAT   = 1 + NSAMP * 16;
  localparam int LIMIT = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] ch_mask = 4'b0;
  logic       compares;
  logic [7:0] dac_code;
  logic [1:0] ch_sel;
  logic       busy;
  logic       result_valid;
  logic [7:0] result;
  logic [1:0] result_ch;

  logic [7:0] vin [4];
  logic [7:0] trace [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign compares = (vin[ch_sel] >= dac_code);

  sar_adc_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ch_mask      (ch_mask),
    .compares     (compares),
    .dac_code     (dac_code),
    .ch_sel       (ch_sel),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .result_ch    (result_ch)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_dac"}, 32'(dac_code), 0);
    chk({tag, "_ch_sel"}, 32'(ch_sel), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(result_valid), 0);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_result_ch"}, 32'(result_ch), 0);
  endtask

  // Launch a scan and follow it to the end. Optionally injects a second
  // start (with a different mask) mid-scan, which must be ignored.
  task automatic run_scan(input string name, input logic [3:0] mask,
                          input int inj_cyc, input logic [3:0] inj_mask,
                          input int exp_n, input logic [1:0] ca, input logic [7:0] ra,
                          input logic [1:0] cb, input logic [7:0] rb);
    int cyc = 0;
    int n = 0;
    logic [3:0] seen = 4'b0;
    logic [7:0] prev_res;
    logic stable = 1'b1;
    @(negedge clk);
    start = 1'b1;
    ch_mask = mask;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_rise"}, 32'(busy), 1);
    chk({name, "_dac_settle"}, 32'(dac_code), 0);
    prev_res = result;
    trace.delete();
    while (cyc < LIMIT) begin
      if (busy) seen[ch_sel] = 1'b1;
      @(negedge clk);
      cyc++;
      if (cyc == inj_cyc) begin
        start = 1'b1;
        ch_mask = inj_mask;
      end else if (cyc == inj_cyc + 1) begin
        start = 1'b0;
      end
      if (dac_code != 8'h00 && (trace.size() == 0 || trace[$] != dac_code))
        trace.push_back(dac_code);
      if (result_valid) begin
        n++;
        chk({name, "_res_ch"}, 32'(result_ch), (n == 1) ? 32'(ca) : 32'(cb));
        chk({name, "_res"}, 32'(result), (n == 1) ? 32'(ra) : 32'(rb));
        chk({name, "_latency"}, cyc, n * LAT);
        chk({name, "_busy_at_valid"}, 32'(busy), (n == exp_n) ? 32'd0 : 32'd1);
        prev_res = result;
      end else if (result !== prev_res) begin
        stable = 1'b0;
      end
      if (!busy) break;
    end
    chk({name, "_done_in_time"}, 32'(cyc < LIMIT), 1);
    chk({name, "_n_results"}, n, exp_n);
    chk({name, "_ch_only_masked"}, 32'(seen & ~mask), 0);
    chk({name, "_result_held"}, 32'(stable), 1);
    @(negedge clk);
    chk({name, "_no_extra_valid"}, 32'(result_valid), 0);
    ch_mask = 4'b0;
  endtask

  typedef struct {
    string      name;
    logic [3:0] mask;
    logic [31:0] vins;   // {ch3, ch2, ch1, ch0}
    int         n;
    logic [1:0] ca;
    logic [7:0] ra;
    logic [1:0] cb;
    logic [7:0] rb;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{"v80",    4'b0001, 32'h0000_0080, 1, 2'd0, 8'h80, 2'd0, 8'h00};
    vt[1] = '{"v00",    4'b0001, 32'h0000_0000, 1, 2'd0, 8'h00, 2'd0, 8'h00};
    vt[2] = '{"vFF",    4'b0001, 32'h0000_00FF, 1, 2'd0, 8'hFF, 2'd0, 8'h00};
    vt[3] = '{"m1010",  4'b1010, 32'hCA00_3500, 2, 2'd1, 8'h35, 2'd3, 8'hCA};
    vt[4] = '{"ch2",    4'b0100, 32'h005A_0000, 1, 2'd2, 8'h5A, 2'd0, 8'h00};
    vt[5] = '{"ch3_01", 4'b1000, 32'h0100_0000, 1, 2'd3, 8'h01, 2'd0, 8'h00};
    for (int i = 0; i < 4; i++) vin[i] = 8'h00;

    // Reset state while rst is held.
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 4; c++) vin[c] = vt[i].vins[c*8 +: 8];
      run_scan(vt[i].name, vt[i].mask, -1, 4'b0, vt[i].n,
               vt[i].ca, vt[i].ra, vt[i].cb, vt[i].rb);
    end

    // DAC trial sequence for a full-scale input.
    vin[0] = 8'hFF;
    run_scan("trace", 4'b0001, -1, 4'b0, 1, 2'd0, 8'hFF, 2'd0, 8'h00);
    chk("trace_len", trace.size(), 8 * NSAMP);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ones = 8'hFF;
      chk($sformatf("trace_%0d", i), (i < trace.size()) ? 32'(trace[i]) : 32'hDEAD,
          32'(8'(ones << (7 - i))));
    end

    // Start while busy (with a different mask) must not disturb the scan.
    vin[0] = 8'h80;
    vin[1] = 8'h11;
    vin[2] = 8'h22;
    vin[3] = 8'h33;
    run_scan("midstart", 4'b0001, 5, 4'b1111, 1, 2'd0, 8'h80, 2'd0, 8'h00);

    // Start with an empty mask in IDLE is ignored.
    @(negedge clk);
    start = 1'b1;
    ch_mask = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mask0_busy", 32'(busy), 0);
      chk("mask0_valid", 32'(result_valid), 0);
      chk("mask0_result", 32'(result), 32'h80);
      @(negedge clk);
    end

    // Reset in the middle of bit 4, then a clean conversion.
    vin[0] = 8'h80;
    @(negedge clk);
    start = 1'b1;
    ch_mask = 4'b0001;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_mid_dac_bit4", 32'(dac_code), 32'h90);
    rst = 1'b1;
    #1;
    chk_zero_outputs("rst_mid");
    @(negedge clk);
    chk_zero_outputs("rst_hold");
    rst = 1'b0;
    vin[1] = 8'h3C;
    run_scan("after_rst", 4'b0010, -1, 4'b0, 1, 2'd1, 8'h3C, 2'd0, 8'h00);

`ifdef SAR_AVG_EN
    // Dithered samples 0x10, 0x11, 0x11, 0x12 average to 0x11.
    begin
      logic [7:0] smp [4];
      int cyc = 0;
      int n = 0;
      smp[0] = 8'h10; smp[1] = 8'h11; smp[2] = 8'h11; smp[3] = 8'h12;
      vin[0] = smp[0];
      @(negedge clk);
      start = 1'b1;
      ch_mask = 4'b0001;
      @(negedge clk);
      start = 1'b0;
      while (busy && cyc < LIMIT) begin
        @(negedge clk);
        cyc++;
        if (cyc == 17 || cyc == 33 || cyc == 49) vin[0] = smp[(cyc - 1) / 16];
        if (result_valid) begin
          n++;
          chk("avg_result", 32'(result), 32'h11);
          chk("avg_latency", cyc, 65);
        end
      end
      chk("avg_n_results", n, 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
